mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide sequencer for the pipelined MIPS core. Sits beside the ALU in the E stage, owns the HI/LO registers, and runs multi-cycle multiply and divide operations issued by the control decoder. Raises a stall request so that later HI/LO-related instructions in D wait until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MDOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- start  input  1  E-stage instruction is a valid MD op (qualifies MDOp)
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- md_pending  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- HI  output  32  HI register
- LO  output  32  LO register
- busy  output  1  multi-cycle operation in progress
- MDStall  output  1  stall request to the hazard unit

## Operation
- States: IDLE (count = 0), RUN (count != 0). busy = (count != 0).
- IDLE, start with op 1–4: latch A, B and op; compute the result into a pending HI/LO pair; load count with MULT_CYCLES or DIV_CYCLES; enter RUN.
- IDLE, start with op 5/6: write A into HI or LO at that edge; stay IDLE; busy stays 0.
- RUN: count decrements by 1 each cycle. On the edge where count goes 1 -> 0, commit the pending pair to HI/LO and return to IDLE.
- start while busy is a protocol violation, because MDStall prevents it. The op is ignored, and in-flight state and HI/LO are unaffected.
- mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0]. multu: unsigned.
- div: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. divu: unsigned.
- Divide by zero (B = 0): unit still goes busy for DIV_CYCLES. HI/LO are left unchanged at commit.
- MDStall = md_pending & (busy | (start & MDOp in 1..4)). This is combinational and holds D and F while asserted.
- mfhi/mflo read HI/LO directly. Since MDStall blocks them while busy, they never observe a stale value.

## Timing
- Reset: HI = 0, LO = 0, count = 0, busy = 0, MDStall = md_pending & start-term only. A reset mid-operation discards the pending result.
- start of a mult/multu at edge t: busy is 1 from after edge t through before edge t+MULT_CYCLES. HI/LO are updated at edge t+MULT_CYCLES and are visible in the same cycle that busy drops.
- div/divu: same timing, using DIV_CYCLES.
- mthi/mtlo: HI/LO are updated at the issuing edge, so there is 1 cycle of latency and no busy.
- A D-stage MD instruction proceeds to E in the first cycle in which busy = 0, so back-to-back mults are spaced MULT_CYCLES+1 apart.

## Configuration
- MDU_DIV_EN defined: div/divu are executed as described above.
- MDU_DIV_EN undefined:
  - no divider is synthesized;
  - ops 3/4 are treated as none: no busy, HI/LO unchanged, and they do not contribute to MDStall.

## Test plan
- Reset, then mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div by B=0 -> HI/LO unchanged, busy still 10 cycles.
- mtlo A=0x12345678 -> LO=0x12345678 the next cycle, busy stays 0. Then mfhi pending while a mult is running -> MDStall=1 every busy cycle and 0 the cycle busy drops.
- mult started, reset asserted at count=3 -> next cycle HI=LO=0, busy=0, no later commit.
- With MDU_DIV_EN undefined: divu start with md_pending=1 -> MDStall=0, busy=0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the E stage. Owns HI/LO, runs
// multi-cycle mult/multu/div/divu and raises MDStall toward the hazard unit.
// The result is computed when the op is accepted, held in a pending pair,
// and committed to HI/LO on the edge where the busy counter reaches zero.
// Build option: define MDU_DIV_EN to include the divider (div/divu).
// Without it, ops 3/4 behave as no-ops and never stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_pending,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        MDStall
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        is_mul, is_div, is_mthi, is_mtlo, long_op;
  logic [63:0] mul_res;
`ifdef MDU_DIV_EN
  logic [63:0] div_res;
`endif

  // Full 64-bit product; signed operands are sign-extended so one
  // 64-bit multiply covers both mult and multu.
  function automatic logic [63:0] mul_full(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        is_signed);
    logic [63:0] ax, bx;
    ax = {{32{is_signed & a[31]}}, a};
    bx = {{32{is_signed & b[31]}}, b};
    return ax * bx;
  endfunction

`ifdef MDU_DIV_EN
  // Returns {remainder, quotient}. Signed divide works on magnitudes:
  // quotient truncates toward zero, remainder takes the dividend's sign.
  // A zero divisor is forced to 1 here; the caller discards that result.
  function automatic logic [63:0] div_full(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        is_signed);
    logic        neg_a, neg_b;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_out, r_out;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    a_mag = neg_a ? (~a + 32'd1) : a;
    b_mag = neg_b ? (~b + 32'd1) : b;
    if (b_mag == 32'd0) b_mag = 32'd1;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    q_out = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    r_out = neg_a ? (~r_mag + 32'd1) : r_mag;
    return {r_out, q_out};
  endfunction
`endif

  // Decode the qualified E-stage op.
  always_comb begin
    is_mul  = start & ((MDOp == 3'd1) | (MDOp == 3'd2));
`ifdef MDU_DIV_EN
    is_div  = start & ((MDOp == 3'd3) | (MDOp == 3'd4));
`else
    is_div  = 1'b0;
`endif
    is_mthi = start & (MDOp == 3'd5);
    is_mtlo = start & (MDOp == 3'd6);
    long_op = is_mul | is_div;
  end

  // State register: busy counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Pending result pair; only meaningful while pend_wr_q and count are live.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  // Next state: accept ops only when idle, count down and commit when running.
  always_comb begin
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    mul_res   = mul_full(A, B, MDOp == 3'd1);
`ifdef MDU_DIV_EN
    div_res   = div_full(A, B, MDOp == 3'd3);
`endif
    if (count_q == 4'd0) begin
      if (is_mul) begin
        pend_hi_d = mul_res[63:32];
        pend_lo_d = mul_res[31:0];
        pend_wr_d = 1'b1;
        count_d   = MULT_LOAD;
`ifdef MDU_DIV_EN
      end else if (is_div) begin
        pend_hi_d = div_res[63:32];
        pend_lo_d = div_res[31:0];
        // Divide by zero still occupies the unit but leaves HI/LO alone.
        pend_wr_d = (B != 32'd0);
        count_d   = DIV_LOAD;
`endif
      end else if (is_mthi) begin
        hi_d = A;
      end else if (is_mtlo) begin
        lo_d = A;
      end
    end else begin
      // Any start seen here is ignored: the stall should have blocked it.
      count_d = count_q - 4'd1;
      if ((count_q == 4'd1) && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  // Outputs: busy flag and combinational stall request.
  always_comb begin
    busy    = (count_q != 4'd0);
    MDStall = md_pending & (busy | long_op);
    HI      = hi_q;
    LO      = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes expected HI/LO and busy
// length for every accepted op; a monitor pops and compares on completion.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  MDOp = 3'd0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        md_pending = 1'b0;
  logic [31:0] HI, LO;
  logic        busy, MDStall;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .start(start), .A(A), .B(B),
    .md_pending(md_pending), .HI(HI), .LO(LO), .busy(busy), .MDStall(MDStall)
  );

  typedef struct {
    bit          is_long;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic bit is_long_op(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 1'b1;
`ifdef MDU_DIV_EN
    if (op == 3'd3 || op == 3'd4) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: what HI/LO become after op, from plain arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint      sa, sb, ua, ub, qv, rv;
    logic [63:0] p;
    logic [31:0] nh, nl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    nh = m_hi;
    nl = m_lo;
    case (op)
      3'd1: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; nh = p[63:32]; nl = p[31:0]; end
      3'd3: if (is_long_op(op) && b != 32'd0) begin
              qv = sa / sb; rv = sa % sb;
              p = 64'(qv); nl = p[31:0];
              p = 64'(rv); nh = p[31:0];
            end
      3'd4: if (is_long_op(op) && b != 32'd0) begin
              qv = ua / ub; rv = ua % ub;
              p = 64'(qv); nl = p[31:0];
              p = 64'(rv); nh = p[31:0];
            end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
    e.is_long = is_long_op(op);
    e.hi = nh;
    e.lo = nl;
    e.len = (op == 3'd1 || op == 3'd2) ? MC : DC;
    m_hi = nh;
    m_lo = nl;
  endtask

  // Wait (bounded) for the first cycle with busy low; leaves us at posedge+1.
  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, n);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic pend);
    exp_t e;
    wait_idle();
    model(op, a, b, e);
    sb_q.push_back(e);
    md_pending = pend;
    start = 1'b1;
    MDOp = op;
    A = a;
    B = b;
    @(posedge clk); #1;
    start = 1'b0;
    MDOp = 3'($urandom);
    A = $urandom;
    B = $urandom;
  endtask

  // Illegal start while busy: must be ignored, nothing expected.
  task automatic violate();
    start = 1'b1;
    MDOp = 3'($urandom_range(1, 6));
    A = $urandom;
    B = $urandom;
    md_pending = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: stall formula every cycle, completions against the scoreboard.
  int run = 0;
  bit rst_chk = 1'b0;
  bit short_chk = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check32("mdstall", {31'd0, MDStall},
            {31'd0, md_pending & (busy | (start & is_long_op(MDOp)))});
    if (rst_chk) begin
      check32("reset_hi", HI, 32'd0);
      check32("reset_lo", LO, 32'd0);
      check32("reset_busy", {31'd0, busy}, 32'd0);
      rst_chk = 1'b0;
    end
    if (short_chk) begin
      short_chk = 1'b0;
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL short_pop: scoreboard empty, got HI %h LO %h", HI, LO);
      end else begin
        e = sb_q.pop_front();
        check32("short_kind", {31'd0, e.is_long}, 32'd0);
        check32("short_hi", HI, e.hi);
        check32("short_lo", LO, e.lo);
        check32("short_busy", {31'd0, busy}, 32'd0);
      end
    end
    if (reset) begin
      sb_q.delete();
      run = 0;
      rst_chk = 1'b1;
    end else begin
      if (busy) begin
        run++;
      end else if (run > 0) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL commit_pop: unexpected commit, got HI %h LO %h len %0d", HI, LO, run);
        end else begin
          e = sb_q.pop_front();
          check32("long_kind", {31'd0, e.is_long}, 32'd1);
          check32("long_hi", HI, e.hi);
          check32("long_lo", LO, e.lo);
          check32("busy_len", 32'(run), 32'(e.len));
        end
        run = 0;
      end
      if (start && !busy && !is_long_op(MDOp)) short_chk = 1'b1;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Test-plan values, also cross-checked with fixed constants.
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    check32("plan_mult_hi", HI, 32'hFFFF_FFFF);
    check32("plan_mult_lo", LO, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();
    check32("plan_multu_hi", HI, 32'h0000_0001);
    check32("plan_multu_lo", LO, 32'hFFFF_FFFE);
`ifdef MDU_DIV_EN
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    check32("plan_div_hi", HI, 32'hFFFF_FFFF);
    check32("plan_div_lo", LO, 32'hFFFF_FFFD);
    issue(3'd3, 32'h1234_0000, 32'd0, 1'b1);
    wait_idle();
    check32("plan_div0_hi", HI, 32'hFFFF_FFFF);
    check32("plan_div0_lo", LO, 32'hFFFF_FFFD);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check32("plan_divovf_hi", HI, 32'h0000_0000);
    check32("plan_divovf_lo", LO, 32'h8000_0000);
`else
    begin
      exp_t e;
      wait_idle();
      model(3'd4, 32'd100, 32'd7, e);
      sb_q.push_back(e);
      md_pending = 1'b1;
      start = 1'b1; MDOp = 3'd4; A = 32'd100; B = 32'd7;
      #1 check32("nodiv_stall", {31'd0, MDStall}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check32("nodiv_busy", {31'd0, busy}, 32'd0);
      check32("nodiv_lo", LO, 32'hFFFF_FFFE);
    end
`endif
    issue(3'd6, 32'h1234_5678, 32'd0, 1'b0);
    check32("plan_mtlo_lo", LO, 32'h1234_5678);
    check32("plan_mtlo_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b1);
    check32("plan_mthi_hi", HI, 32'hCAFE_F00D);

    // mult with an MD instruction pending in D, plus an illegal start.
    issue(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b1);
    violate();
    md_pending = 1'b1;
    wait_idle();
    check32("plan_stall_hi", HI, 32'h0000_0001);
    check32("plan_stall_lo", LO, 32'h0000_0000);

    // Reset while the mult counter is at 3.
    issue(3'd1, 32'h0000_0007, 32'h0000_0009, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (8) @(posedge clk);
    #1;
    check32("rst_late_hi", HI, 32'd0);
    check32("rst_late_lo", LO, 32'd0);
    check32("rst_late_busy", {31'd0, busy}, 32'd0);

    // Randomized ops with random D-stage pending and occasional illegal starts.
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, pick(), pick(), 1'($urandom_range(0, 1)));
      if (is_long_op(op) && $urandom_range(0, 4) == 0) violate();
      md_pending = 1'($urandom_range(0, 1));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
